// File: rtl/mem_axi_bridge_if.sv
// axi_if: AXI4 channel bundle (AR/R/AW/W/B) shared by the bridge master and the RAM slave.
interface axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: single-outstanding load/store port to AXI4 single-beat master.
// Optional address window check enabled by defining MEM_AXI_RANGE_CHECK_EN.
module mem_axi_bridge #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] START_ADDR = 32'h8000_0000,
  parameter int          DATA_SIZE  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [3:0]            req_wstrb,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  axi_if.master                 m_axi
);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [29:0]           waddr;
    logic [3:0]            wstrb;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_n;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q, range_err, acc, r_hs, b_hs;
  logic                  ar_on, aw_on, w_on;

  assign acc  = req_valid && req_ready;
  assign r_hs = m_axi.rvalid && m_axi.rready;
  assign b_hs = m_axi.bvalid && m_axi.bready;

`ifdef MEM_AXI_RANGE_CHECK_EN
  // 33-bit compare so a window ending at 2^32 does not wrap.
  localparam logic [32:0] END_ADDR = {1'b0, START_ADDR} + 33'(4 * DATA_SIZE);
  assign range_err = ({1'b0, req_addr} < {1'b0, START_ADDR}) || ({1'b0, req_addr} >= END_ADDR);
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        req_q   <= '{we: req_we, waddr: req_addr[31:2], wstrb: req_wstrb, wdata: req_wdata};
        rdata_q <= '0;
        err_q   <= range_err;
      end
      if (r_hs) begin
        rdata_q <= m_axi.rdata;
        err_q   <= (m_axi.rresp != 2'b00);
      end
      if (b_hs) begin
        rdata_q <= '0;
        err_q   <= (m_axi.bresp != 2'b00);
      end
    end
  end

  always_comb begin
    state_n      = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    ar_on        = 1'b0;
    aw_on        = 1'b0;
    w_on         = 1'b0;
    m_axi.rready = 1'b0;
    m_axi.bready = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = range_err ? S_RESP : (req_we ? S_AW : S_AR);
      end
      S_AR:   begin ar_on = 1'b1;        if (m_axi.arready) state_n = S_R;    end
      S_R:    begin m_axi.rready = 1'b1; if (m_axi.rvalid)  state_n = S_RESP; end
      S_AW:   begin aw_on = 1'b1;        if (m_axi.awready) state_n = S_W;    end
      S_W:    begin w_on = 1'b1;         if (m_axi.wready)  state_n = S_B;    end
      S_B:    begin m_axi.bready = 1'b1; if (m_axi.bvalid)  state_n = S_RESP; end
      S_RESP: begin resp_valid = 1'b1;   if (resp_ready)    state_n = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
  end

  // Address/data fields are zeroed whenever their valid is low.
  assign m_axi.arvalid = ar_on;
  assign m_axi.arid    = '0;
  assign m_axi.araddr  = ar_on ? {req_q.waddr, 2'b00} : '0;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = ar_on ? 3'b010 : 3'b000;
  assign m_axi.arburst = ar_on ? 2'b01 : 2'b00;

  assign m_axi.awvalid = aw_on;
  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = aw_on ? {req_q.waddr, 2'b00} : '0;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = aw_on ? 3'b010 : 3'b000;
  assign m_axi.awburst = aw_on ? 2'b01 : 2'b00;

  assign m_axi.wvalid  = w_on;
  assign m_axi.wlast   = w_on;
  assign m_axi.wdata   = w_on ? req_q.wdata : '0;
  assign m_axi.wstrb   = w_on ? req_q.wstrb : '0;

  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;

  logic unused_ok;
  assign unused_ok = ^{m_axi.bid, m_axi.rid, m_axi.rlast, req_addr[1:0], START_ADDR, 32'(DATA_SIZE)};
endmodule
